// File: rtl/log_pkg.sv
// Shared types and constants for the natural-log engine: FSM states, default sizes
// and the ln(1+2^-k) table.
package log_pkg;

    localparam int DEF_GUARD = 4;
    localparam int DEF_NITER = 17;
    localparam int QF        = 16;
    localparam int LUT_FW    = 20;
    localparam int LUT_N     = 17;
    localparam int K_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } log_state_t;

    // ln(1+2^-k) in Q1.20, truncated; entry 0 is ln2 for the doubling step
    localparam logic [LUT_FW:0] LOG_LUT [LUT_N] = '{
        21'd726817, 21'd425160, 21'd233982, 21'd123504,
        21'd63569,  21'd32266,  21'd16257,  21'd8160,
        21'd4088,   21'd2046,   21'd1023,   21'd511,
        21'd255,    21'd127,    21'd63,     21'd31,
        21'd15
    };

    function automatic logic [LUT_FW:0] log_lut(input logic [K_W-1:0] k);
        logic [LUT_FW:0] v;
        v = '0;
        if (int'(k) < LUT_N)
            v = LOG_LUT[k];
        return v;
    endfunction

endpackage

// File: rtl/logController.sv
// Sequencer for the log engine: IDLE -> LOAD -> ITER x NITER -> DONE, with the
// iteration counter and registered datapath strobes.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch y, W=1.0, ACC=0
// ITER  | one shift-and-add step per cycle, k = 0..NITER-1
// DONE  | result registers valid, done pulse high
module logController
    import log_pkg::*;
#(
    parameter int NITER = DEF_NITER
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [K_W-1:0] k,
    output logic           ldy,
    output logic           initw,
    output logic           ldw,
    output logic           ldacc,
    output logic           ldres,
    output logic           done
);

    localparam logic [K_W-1:0] K_LAST = K_W'(NITER - 1);

    log_state_t state;
    logic       enk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            ldy   <= 1'b0;
            initw <= 1'b0;
            ldw   <= 1'b0;
            ldacc <= 1'b0;
            enk   <= 1'b0;
            ldres <= 1'b0;
            done  <= 1'b0;
        end else begin
            ldy   <= 1'b0;
            initw <= 1'b0;
            ldw   <= 1'b0;
            ldacc <= 1'b0;
            enk   <= 1'b0;
            ldres <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ldy   <= 1'b1;
                        initw <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= ITER;
                    k     <= '0;
                    ldw   <= 1'b1;
                    ldacc <= 1'b1;
                    enk   <= 1'b1;
                    ldres <= (K_LAST == '0);
                end
                ITER: begin
                    if (k == K_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        if (enk)
                            k <= k + 1'b1;
                        ldw   <= 1'b1;
                        ldacc <= 1'b1;
                        enk   <= 1'b1;
                        // result is captured alongside the final step's ACC update
                        ldres <= ((k + 1'b1) == K_LAST);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/logDatapath.sv
// Y/W/ACC registers, shift-add comparator and LUT accumulate for the log engine.
// Optional LOG_ROUND_EN rounds the Q1.(16+GUARD) accumulator to nearest Q1.16.
module logDatapath
    import log_pkg::*;
#(
    parameter int GUARD = DEF_GUARD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ldy,
    input  logic           initw,
    input  logic           ldw,
    input  logic           ldacc,
    input  logic           ldres,
    input  logic [K_W-1:0] k,
    input  logic [1:0]     yint,
    input  logic [15:0]    yfrac,
    output logic           err,
    output logic           intpart,
    output logic [15:0]    fracpart
);

    localparam int FW = QF + GUARD;
    localparam int YW = FW + 2;
    localparam int AW = FW + 1;
    localparam int RW = QF + 1;
    localparam logic [YW-1:0] W_ONE = {2'b01, {FW{1'b0}}};

    logic [YW-1:0] yreg;
    logic [YW-1:0] wreg;
    logic [YW-1:0] wsh;
    logic [YW:0]   t;
    logic          take;
    logic [AW-1:0] acc;
    logic [AW-1:0] lut;
    logic [AW-1:0] acc_nxt;
    logic [RW-1:0] res;

    // table is stored at 20 fraction bits, so GUARD must not exceed 4
    always_comb begin
        wsh     = wreg >> k;
        t       = {1'b0, wreg} + {1'b0, wsh};
        take    = (t <= {1'b0, yreg});
        lut     = AW'(log_lut(k) >> (LUT_FW - FW));
        acc_nxt = take ? (acc + lut) : acc;
    end

`ifdef LOG_ROUND_EN
    logic [RW:0] rq;
    always_comb begin
        rq  = (RW + 1)'(({1'b0, acc_nxt} + (AW + 1)'(1 << (GUARD - 1))) >> GUARD);
        res = rq[RW] ? {RW{1'b1}} : rq[RW-1:0];
    end
`else
    always_comb begin
        res = acc_nxt[AW-1:GUARD];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yreg     <= '0;
            wreg     <= '0;
            acc      <= '0;
            err      <= 1'b0;
            intpart  <= 1'b0;
            fracpart <= '0;
        end else begin
            if (ldy) begin
                yreg <= {yint, yfrac, {GUARD{1'b0}}};
                err  <= (yint == 2'd0);
            end
            if (initw) begin
                wreg <= W_ONE;
                acc  <= '0;
            end
            if (ldw && take)
                wreg <= t[YW-1:0];
            if (ldacc)
                acc <= acc_nxt;
            if (ldres)
                {intpart, fracpart} <= err ? {RW{1'b0}} : res;
        end
    end

endmodule

// File: rtl/logarithm.sv
// Natural-log engine top: ln(y) for Q2.16 y in [1,4), Q1.16 result, start/done handshake.
// Define LOG_ROUND_EN to round the result to nearest instead of truncating.
module logarithm
    import log_pkg::*;
#(
    parameter int GUARD = DEF_GUARD,
    parameter int NITER = DEF_NITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  yint,
    input  logic [15:0] yfrac,
    output logic        done,
    output logic        err,
    output logic        intpart,
    output logic [15:0] fracpart
);

    logic [K_W-1:0] k;
    logic           ldy;
    logic           initw;
    logic           ldw;
    logic           ldacc;
    logic           ldres;

    logController #(.NITER(NITER)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k     (k),
        .ldy   (ldy),
        .initw (initw),
        .ldw   (ldw),
        .ldacc (ldacc),
        .ldres (ldres),
        .done  (done)
    );

    logDatapath #(.GUARD(GUARD)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .ldy      (ldy),
        .initw    (initw),
        .ldw      (ldw),
        .ldacc    (ldacc),
        .ldres    (ldres),
        .k        (k),
        .yint     (yint),
        .yfrac    (yfrac),
        .err      (err),
        .intpart  (intpart),
        .fracpart (fracpart)
    );

endmodule

// File: tb/tb_logarithm.sv
// Bench for the log engine: cycle-level model of the handshake plus a real-valued ln reference.
module tb_logarithm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  yint;
    logic [15:0] yfrac;
    logic        done;
    logic        err;
    logic        intpart;
    logic [15:0] fracpart;

    always #5 clk = ~clk;

    logarithm dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .yint     (yint),
        .yfrac    (yfrac),
        .done     (done),
        .err      (err),
        .intpart  (intpart),
        .fracpart (fracpart)
    );

    int checks = 0;
    int errors = 0;

    // reference model: accepted start at cycle n -> done exactly at n+19, idle again at n+20
    int          cyc = 0;
    int          due = -1;
    int          free_at = 0;
    logic [17:0] m_y = '0;

    task automatic check_result(input logic [17:0] yv);
        logic [16:0] res;
        real         lnr;
        int          ref_v;
        int          d;
        res = {intpart, fracpart};
        checks++;
        if (yv < 18'h10000) begin
            if (err !== 1'b1 || res !== 17'h0) begin
                errors++;
                $display("FAIL errcase y=%05h got err=%0b res=%05h want err=1 res=00000", yv, err, res);
            end
        end else begin
            lnr   = $ln(real'(yv) / 65536.0) * 65536.0;
            ref_v = int'($floor(lnr));
            d     = int'(res) - ref_v;
            if (err !== 1'b0 || d > 2 || d < -2) begin
                errors++;
                $display("FAIL lnval y=%05h got err=%0b res=%05h want err=0 res=%05h +/-2", yv, err, res, ref_v);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            checks++;
            if ({done, err, intpart, fracpart} !== 19'h0) begin
                errors++;
                $display("FAIL reset_outs got done=%0b err=%0b res=%05h want all 0", done, err, {intpart, fracpart});
            end
            due     = -1;
            free_at = cyc + 1;
        end else begin
            checks++;
            if (done !== (cyc == due)) begin
                errors++;
                $display("FAIL done_timing cyc=%0d got done=%0b want %0b", cyc, done, (cyc == due));
            end
            if (cyc == due)
                check_result(m_y);
            if (cyc >= free_at && start) begin
                due     = cyc + 19;
                free_at = cyc + 20;
                m_y     = {yint, yfrac};
            end
        end
    end

    task automatic run(input logic [17:0] yv, output logic [16:0] res, output logic e);
        logic got;
        @(posedge clk); #1;
        {yint, yfrac} = yv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        res = '0;
        e   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                res = {intpart, fracpart};
                e   = err;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout y=%05h got no done want done within 40 cycles", yv);
        end
    endtask

    task automatic expect_near(input string name, input logic [16:0] got, input logic ge,
                               input int want, input int tol, input logic want_e);
        int d;
        d = int'(got) - want;
        checks++;
        if (ge !== want_e || d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s got err=%0b res=%05h want err=%0b res=%05h +/-%0d", name, ge, got, want_e, want, tol);
        end
    endtask

    logic [16:0] r;
    logic        e;
    logic [17:0] yv;
    int          cnt;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        yint  = '0;
        yfrac = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(18'h10000, r, e);  expect_near("y_1p0",  r, e, 17'h00000, 0, 1'b0);
        run(18'h20000, r, e);  expect_near("y_2p0",  r, e, 17'h0B172, 2, 1'b0);
        run(18'h2B7E1, r, e);  expect_near("y_e",    r, e, 17'h0FFFF, 2, 1'b0);
        run(18'h3FFFF, r, e);  expect_near("y_max",  r, e, 17'h162E4, 2, 1'b0);
        run(18'h0FFFF, r, e);  expect_near("y_lt1",  r, e, 17'h00000, 0, 1'b1);
        run(18'h20000, r, e);  expect_near("errclr", r, e, 17'h0B172, 2, 1'b0);
        run(18'h18000, r, e);  expect_near("y_1p5",  r, e, 17'h067CC, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(7) == 0)
                yv = 18'($urandom_range(32'h0FFFF));
            else
                yv = 18'($urandom_range(32'h3FFFF, 32'h10000));
            run(yv, r, e);
        end

        // start held high: back-to-back runs
        @(posedge clk); #1;
        {yint, yfrac} = 18'h28000;
        start = 1'b1;
        repeat (45) @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(posedge clk);

        // start pulsed mid-run must be ignored
        @(posedge clk); #1;
        {yint, yfrac} = 18'h20000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL midstart got %0d done pulses want 1", cnt);
        end

        // reset at c0+8 aborts the run
        @(posedge clk); #1;
        {yint, yfrac} = 18'h30000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, err, intpart, fracpart} !== 19'h0) begin
            errors++;
            $display("FAIL abort_outs got done=%0b err=%0b res=%05h want all 0", done, err, {intpart, fracpart});
        end
        repeat (30) @(posedge clk);

        run(18'h30000, r, e);  expect_near("y_3p0", r, e, 17'h1193E, 2, 1'b0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
